// File: rtl/gpr_pkg.sv
// Shared GPR definitions: register file geometry, writeback requester indices
// and the packed {addr, data} write-request pair.
`default_nettype none

package gpr_pkg;

    localparam int GPR_AW  = 5;
    localparam int GPR_DW  = 32;
    localparam int GPR_NUM = 32;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_LINK = 2;

    typedef struct packed {
        logic [GPR_AW-1:0] addr;
        logic [GPR_DW-1:0] data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/gpr_wb_sched_if.sv
// Writeback request bundle: NREQ packed valid/addr/data lanes and the
// per-lane ready (grant) returned by the scheduler.
`default_nettype none

interface gpr_wb_sched_if
    import gpr_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = GPR_AW,
    parameter int DW   = GPR_DW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// NREQ-way one-hot grant: round-robin from a rotating pointer, or fixed
// lowest-index priority when ARB_FIXED is nonzero.
`default_nettype none

module rr_arbiter #(
    parameter int  NREQ      = 3,
    parameter int  ARB_FIXED = 0,
    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [NREQ-1:0] i_valid,
    input  wire logic            i_stall,
    output logic      [NREQ-1:0] o_grant,
    output logic      [PW-1:0]   o_idx
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (ARB_FIXED != 0) ? k : (int'(ptr_q) + k) % NREQ;
            if (!found && i_valid[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = PW'(cand);
            end
        end
        // Grants are suppressed while held in reset so nothing is consumed.
        if (i_stall || !reset) begin
            o_grant = '0;
            found   = 1'b0;
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (o_idx == PW'(NREQ - 1)) ? '0 : o_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpr_wb_sched.sv
// GPR write-port scheduler: arbitrates writeback sources onto the single
// register-file write port and tracks pending writes. Optional: GPR_WB_TRACE_EN.
`default_nettype none

module gpr_wb_sched
    import gpr_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AW        = GPR_AW,
    parameter int DW        = GPR_DW,
    parameter int ARB_FIXED = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    gpr_wb_sched_if.slave           bus,
    input  wire logic               wb_stall,
    input  wire logic               claim_valid,
    input  wire logic [AW-1:0]      claim_addr,
    input  wire logic               flush,
    output logic                    wr_en,
    output logic      [AW-1:0]      wr_addr,
    output logic      [DW-1:0]      wr_data,
    output logic      [GPR_NUM-1:0] busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    grant;
    logic [PW-1:0]      win_idx;
    logic               accept;
    wb_req_t            sel_req;

    logic               wr_en_q,   wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [DW-1:0]      wr_data_q, wr_data_d;
    logic [GPR_NUM-1:0] busy_q,    busy_d;

    rr_arbiter #(
        .NREQ      (NREQ),
        .ARB_FIXED (ARB_FIXED)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.req_valid),
        .i_stall (wb_stall),
        .o_grant (grant),
        .o_idx   (win_idx)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;

    always_comb begin
        sel_req.addr = bus.req_addr[int'(win_idx)*AW +: AW];
        sel_req.data = bus.req_data[int'(win_idx)*DW +: DW];

        // Writes to $0 are consumed by the grant but never reach the file.
        wr_en_d   = accept && (sel_req.addr != '0);
        wr_addr_d = accept ? sel_req.addr : wr_addr_q;
        wr_data_d = accept ? sel_req.data : wr_data_q;

        // Claim is applied last so it wins over both commit-clear and flush.
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

`ifdef GPR_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wr_en_q) begin
            $display("$%0d <= %h", wr_addr_q, wr_data_q);
        end
    end
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_sched.sv
// Scoreboard bench for gpr_wb_sched: random and directed writeback traffic
// checked against a queue/array reference model; a second instance covers fixed priority.
`default_nettype none

module tb_gpr_wb_sched;
    import gpr_pkg::*;

    logic        clk;
    logic        reset;
    logic        wb_stall, claim_valid, flush;
    logic [4:0]  claim_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    logic        f_wr_en;
    logic [4:0]  f_wr_addr;
    logic [31:0] f_wr_data;
    logic [31:0] f_busy;

    int checks   = 0;
    int failures = 0;

    gpr_wb_sched_if #(.NREQ(3), .AW(5), .DW(32)) bus ();
    gpr_wb_sched_if #(.NREQ(3), .AW(5), .DW(32)) bus_f ();

    gpr_wb_sched #(.NREQ(3), .AW(5), .DW(32), .ARB_FIXED(0)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .wb_stall(wb_stall),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    gpr_wb_sched #(.NREQ(3), .AW(5), .DW(32), .ARB_FIXED(1)) u_fix (
        .clk(clk), .reset(reset), .bus(bus_f), .wb_stall(1'b0),
        .claim_valid(1'b0), .claim_addr(5'd0), .flush(1'b0),
        .wr_en(f_wr_en), .wr_addr(f_wr_addr), .wr_data(f_wr_data), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    wb_req_t     exp_q[$];
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_wr_v;
    logic [4:0]  m_wr_a;
    logic        mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_wr_v = 1'b0;
        m_wr_a = '0;
        exp_q.delete();
    endtask

    function automatic int exp_grant(input logic [2:0] v, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_en_unexpected", {31'b0, wr_en}, 32'd0);
                end else begin
                    wb_req_t r;
                    r = exp_q.pop_front();
                    chk("wr_addr", {27'b0, wr_addr}, {27'b0, r.addr});
                    chk("wr_data", wr_data, r.data);
                end
            end else if (exp_q.size() != 0) begin
                chk("wr_en_missing", {31'b0, wr_en}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input logic st, input logic cv, input logic [4:0] ca,
                        input logic fl, output int g);
        logic [31:0] nb;
        wb_req_t     r;
        @(negedge clk);
        chk("busy", busy, m_busy);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        wb_stall      = st;
        claim_valid   = cv;
        claim_addr    = ca;
        flush         = fl;
        #1;
        g = st ? -1 : exp_grant(v, m_ptr);
        chk("req_ready", {29'b0, bus.req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        nb = m_busy;
        if (m_wr_v) nb[m_wr_a] = 1'b0;
        if (fl) nb = '0;
        if (cv && ca != 5'd0) nb[ca] = 1'b1;
        m_busy = nb;
        m_wr_v = 1'b0;
        if (g >= 0) begin
            m_ptr  = (g + 1) % 3;
            r.addr = a[g*5 +: 5];
            r.data = d[g*32 +: 32];
            if (r.addr != 5'd0) begin
                exp_q.push_back(r);
                m_wr_v = 1'b1;
                m_wr_a = r.addr;
            end
        end
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(3'b000, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0, g);
    endtask

    task automatic claim(input logic [4:0] ca, input logic fl);
        int g;
        step(3'b000, '0, '0, 1'b0, 1'b1, ca, fl, g);
    endtask

    initial begin
        int          g;
        logic        pv [3];
        logic [4:0]  pa [3];
        logic [31:0] pd [3];
        logic [14:0] av;
        logic [95:0] dv;
        logic [2:0]  vv;

        mon_en        = 1'b0;
        reset         = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'h3, 32'h2, 32'h1};
        bus_f.req_valid = 3'b111;
        bus_f.req_addr  = {5'd9, 5'd8, 5'd7};
        bus_f.req_data  = {32'hC, 32'hB, 32'hA};
        wb_stall = 1'b0; claim_valid = 1'b0; claim_addr = '0; flush = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready_forced", {29'b0, bus.req_ready}, 32'd0);
        bus.req_valid = 3'b000;
        #1;
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", {29'b0, bus.req_ready}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Round-robin order 0,1,2,0 from reset; fixed instance keeps granting 0
        for (int i = 0; i < 4; i++) begin
            step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0, 5'd0, 1'b0, g);
            chk("fixed_ready", {29'b0, bus_f.req_ready}, 32'd1);
            if (i > 0) chk("fixed_wr_en", {31'b0, f_wr_en}, 32'd1);
        end
        idle(2);

        step(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        idle(2);

        // Scoreboard: claim, commit-clear, then re-claim on the clearing edge
        claim(5'd8, 1'b0);
        idle(1);
        step(3'b010, {5'd0, 5'd8, 5'd0}, {32'd0, 32'h88, 32'd0}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        idle(2);
        claim(5'd8, 1'b0);
        step(3'b010, {5'd0, 5'd8, 5'd0}, {32'd0, 32'h99, 32'd0}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        claim(5'd8, 1'b0);
        idle(2);
        chk("busy8_held", {31'b0, busy[8]}, 32'd1);

        // $0 write and $0 claim
        step(3'b001, 15'd0, {64'd0, 32'h1234}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        claim(5'd0, 1'b0);
        idle(1);

        // Stall: no grants and the pointer holds
        for (int i = 0; i < 3; i++)
            step(3'b111, {5'd6, 5'd5, 5'd4}, {32'h6, 32'h5, 32'h4}, 1'b1, 1'b0, 5'd0, 1'b0, g);
        step(3'b111, {5'd6, 5'd5, 5'd4}, {32'h6, 32'h5, 32'h4}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        idle(2);

        // Flush + claim leaves only the claimed bit
        claim(5'd3, 1'b0);
        claim(5'd9, 1'b0);
        claim(5'd4, 1'b1);
        idle(1);
        chk("flush_claim", busy, 32'h0000_0010);

        // Randomized traffic with requesters holding until accepted
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && ($urandom % 2 == 0)) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pd[i] = $urandom;
                end
            end
            vv = {pv[2], pv[1], pv[0]};
            av = {pa[2], pa[1], pa[0]};
            dv = {pd[2], pd[1], pd[0]};
            step(vv, av, dv, ($urandom % 5 == 0), ($urandom % 3 == 0),
                 5'($urandom_range(0, 31)), ($urandom % 20 == 0), g);
            if (g >= 0) pv[g] = 1'b0;
        end
        for (int c = 0; c < 10 && (pv[0] || pv[1] || pv[2]); c++) begin
            step({pv[2], pv[1], pv[0]}, {pa[2], pa[1], pa[0]}, {pd[2], pd[1], pd[0]},
                 1'b0, 1'b0, 5'd0, 1'b0, g);
            if (g >= 0) pv[g] = 1'b0;
        end
        idle(2);

        // Reset asserted mid-write
        claim(5'd10, 1'b1);
        step(3'b001, {10'd0, 5'd12}, {64'd0, 32'hCAFEF00D}, 1'b0, 1'b0, 5'd0, 1'b0, g);
        @(negedge clk);
        #2;
        chk("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
        chk("pre_rst_busy", busy, 32'h0000_0400);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("async_rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_ready", {29'b0, bus.req_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        bus.req_valid = 3'b000;
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
